// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: control/status bundle between the game sequencer and its neighbours.
interface game_flow_ctrl_if;
    logic        btn_start;
    logic        btn_pause;
    logic        crash_det;
    logic        finish_det;
    logic        second_tick;
    logic        start_en;
    logic        crash_en;
    logic        finish_en;
    logic        pause;
    logic        reset_game;
    logic [15:0] elapsed;
    logic [31:0] finish_time;

    modport master (
        output btn_start, btn_pause, crash_det, finish_det, second_tick,
        input  start_en, crash_en, finish_en, pause, reset_game, elapsed, finish_time
    );

    modport slave (
        input  btn_start, btn_pause, crash_det, finish_det, second_tick,
        output start_en, crash_en, finish_en, pause, reset_game, elapsed, finish_time
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-state sequencer with BCD play timer, splash enables and finish-time latch.
module game_flow_ctrl #(
    parameter int HOLD_SEC = 5,
    parameter int MAX_MIN  = 99
) (
    input logic             clk,
    input logic             reset_n,
    game_flow_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RUN, PAUSED, CRASHED, FINISHED} state_t;

    localparam logic [15:0] SAT  = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 8'h59};
    localparam logic [15:0] HOLD = 16'(HOLD_SEC);

    state_t      state_q, state_d;
    logic [15:0] elapsed_q, elapsed_d, hold_q, hold_d, finish_q, finish_d, ticked;
    logic        start_en_q, start_en_d, crash_en_q, crash_en_d, finish_en_q, finish_en_d;
    logic        pause_q, pause_d, reset_game_q, reset_game_d;

    // BCD increment of mm:ss that sticks at MAX_MIN:59
    always_comb begin
        ticked = elapsed_q;
        if (elapsed_q != SAT) begin
            ticked[3:0] = elapsed_q[3:0] == 4'd9 ? 4'd0 : elapsed_q[3:0] + 4'd1;
            if (elapsed_q[3:0] == 4'd9) begin
                ticked[7:4] = elapsed_q[7:4] == 4'd5 ? 4'd0 : elapsed_q[7:4] + 4'd1;
                if (elapsed_q[7:4] == 4'd5) begin
                    ticked[11:8] = elapsed_q[11:8] == 4'd9 ? 4'd0 : elapsed_q[11:8] + 4'd1;
                    if (elapsed_q[11:8] == 4'd9)
                        ticked[15:12] = elapsed_q[15:12] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        elapsed_d    = elapsed_q;
        hold_d       = hold_q;
        finish_d     = finish_q;
        reset_game_d = 1'b0;
        case (state_q)
            IDLE: if (bus.btn_start) begin
                state_d      = RUN;
                elapsed_d    = '0;
                reset_game_d = 1'b1;
            end
            RUN: begin
                hold_d = '0;
                if (bus.second_tick) elapsed_d = ticked;
                if (bus.crash_det) state_d = CRASHED;
                else if (bus.finish_det) begin
                    state_d  = FINISHED;
                    finish_d = elapsed_d;
                end else if (bus.btn_pause) state_d = PAUSED;
            end
            PAUSED: begin
                if (bus.btn_start) state_d = IDLE;
                else if (bus.btn_pause) state_d = RUN;
            end
            CRASHED, FINISHED: begin
                if (bus.second_tick) hold_d = hold_q + 16'd1;
                if (bus.btn_start || (HOLD_SEC != 0 && hold_d == HOLD)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        start_en_d  = state_d == IDLE;
        crash_en_d  = state_d == CRASHED;
        finish_en_d = state_d == FINISHED;
        pause_d     = state_d != RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            elapsed_q    <= '0;
            hold_q       <= '0;
            finish_q     <= '0;
            start_en_q   <= 1'b1;
            crash_en_q   <= 1'b0;
            finish_en_q  <= 1'b0;
            pause_q      <= 1'b1;
            reset_game_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            elapsed_q    <= elapsed_d;
            hold_q       <= hold_d;
            finish_q     <= finish_d;
            start_en_q   <= start_en_d;
            crash_en_q   <= crash_en_d;
            finish_en_q  <= finish_en_d;
            pause_q      <= pause_d;
            reset_game_q <= reset_game_d;
        end
    end

    assign bus.start_en    = start_en_q;
    assign bus.crash_en    = crash_en_q;
    assign bus.finish_en   = finish_en_q;
    assign bus.pause       = pause_q;
    assign bus.reset_game  = reset_game_q;
    assign bus.elapsed     = elapsed_q;
    assign bus.finish_time = {16'h0000, finish_q};
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game-state sequencer. Sits directly upstream of the text overlay stage.
- Produces the splash enables (start_en, crash_en, finish_en), pause, the reset_game pulse, and the latched finish time word (finish_time, wired to reg12_out) that the overlay renders.
- Counts elapsed play time in BCD from the overlay's second_tick, so the displayed timer and the latched finish time agree.

Parameters:
- HOLD_SEC, 5: seconds a crash/finish splash is held before auto-return to the start screen; 0 disables auto-return.
- MAX_MIN, 99: minute value at which the elapsed counter saturates (counter holds at MAX_MIN:59).

Ports:
- clk  in  1  system clock (same clock as the overlay).
- reset_n  in  1  asynchronous, active-low reset.
- btn_start  in  1  debounced single-cycle start/restart pulse.
- btn_pause  in  1  debounced single-cycle pause-toggle pulse.
- crash_det  in  1  level from collision logic; player hit sludge.
- finish_det  in  1  level from track logic; player crossed finish line.
- second_tick  in  1  single-cycle pulse once per game second, from the overlay.
- start_en  out  1  start splash enable.
- crash_en  out  1  crash splash enable.
- finish_en  out  1  finish splash enable.
- pause  out  1  freezes the overlay timer and game motion.
- reset_game  out  1  one-cycle pulse that restarts the overlay timer and game objects.
- elapsed  out  16  live BCD time {m_tens, m_ones, s_tens, s_ones}.
- finish_time  out  32  {16'h0000, elapsed snapshot at finish}; drives reg12_out.

Behaviour:
- States: IDLE, RUN, PAUSED, CRASHED, FINISHED. Encoding is free. All outputs are registered.
- Async reset (reset_n=0), forced immediately:
  - state=IDLE, start_en=1, all other enables 0, pause=1, reset_game=0.
  - elapsed=0, finish_time=0, hold counter=0.
- IDLE:
  - start_en=1, pause=1.
  - btn_start -> RUN. Same edge: reset_game=1 for exactly one cycle, elapsed cleared to 0, start_en=0, pause=0.
- RUN:
  - pause=0. Each second_tick increments elapsed BCD: s_ones 9->0 carries to s_tens; s_tens 5->0 carries to m_ones; m_ones 9->0 carries to m_tens.
  - At MAX_MIN:59 the counter saturates (no wrap).
  - Priority, highest first, all evaluated in the same cycle:
    1. crash_det -> CRASHED.
    2. finish_det -> FINISHED.
    3. btn_pause -> PAUSED.
  - A second_tick in the same cycle as the exit is still counted.
  - btn_start is ignored.
- PAUSED:
  - pause=1, elapsed frozen, second_tick ignored.
  - btn_pause -> RUN.
  - crash_det and finish_det are ignored.
  - btn_start -> IDLE, with no reset_game pulse.
- CRASHED:
  - crash_en=1, pause=1. elapsed is frozen. finish_time is not updated.
- FINISHED:
  - finish_en=1, pause=1.
  - On entry, finish_time[15:0] <= post-increment elapsed (includes a same-cycle tick). Upper 16 bits are always 0.
  - finish_time holds its value until the next FINISHED entry or reset.
- Hold/exit for CRASHED and FINISHED:
  - Hold counter clears on entry and increments on each second_tick.
  - When HOLD_SEC!=0 and counter==HOLD_SEC -> IDLE.
  - btn_start -> IDLE immediately. This takes precedence over the timeout in the same cycle.
- Enables are mutually exclusive. start_en, crash_en and finish_en are never high together.
- reset_game is only ever asserted on the IDLE->RUN transition.
- Latency: every transition and output change appears on the first clk edge after the qualifying input. No combinational input->output paths.
- Reset mid-operation: any state returns asynchronously to the IDLE reset values above. finish_time is cleared.

Test Plan:
- Reset then start: hold reset_n=0 for 3 cycles, release, pulse btn_start -> IDLE outputs (start_en=1, pause=1) during reset; one cycle after the pulse, reset_game=1 for exactly 1 cycle, start_en=0, pause=0, elapsed=16'h0000.
- BCD carry and finish latch: in RUN, apply 61 second_ticks, then finish_det -> elapsed=16'h0101, state FINISHED, finish_en=1, finish_time=32'h0000_0101.
- Saturation: preload elapsed to 99:58 (apply ticks or force), then apply 3 ticks -> elapsed=16'h9959 and stays there; no wrap to 0000.
- Pause and priority: pulse btn_pause, apply 4 ticks -> elapsed unchanged and pause=1. Pulse btn_pause again to resume. Then assert crash_det and finish_det in the same cycle -> CRASHED, crash_en=1, finish_en=0, finish_time unchanged.
- Hold timeout: with HOLD_SEC=5 in CRASHED, apply 5 ticks -> IDLE after the 5th tick, start_en=1. Repeat with btn_start on the 3rd tick -> IDLE immediately.
- Async reset mid-FINISHED: pull reset_n low between clk edges -> outputs go to reset values without waiting for a clock edge; finish_time=0.
